// File: rtl/wb_line_mem.sv
// wb_line_mem: Wishbone slave line memory for the cache's memory-side port.
// Serves 128-bit line reads and byte-masked line writes after a programmable
// response latency; the array is a plain register RAM that reset never clears.
//
// Optional feature macro: WB_MEM_JITTER_EN
//   defined   - an 8-bit LFSR (seed 8'hA5) adds 0..7 extra cycles per request
//   undefined - fixed latency of LATENCY cycles, no LFSR present
//
// Parameters:
//   ADDR_WIDTH  line-address width, depth = 2**ADDR_WIDTH lines
//   LATENCY     accept edge to ACK, legal 1..255
//
// Ports:
//   CLK    clock, all state on the rising edge
//   RST_N  asynchronous active-low reset
//   CYC    bus cycle valid
//   STB    strobe, request valid when CYC & STB
//   WE     1 = write, 0 = read
//   ADR    line address
//   SEL    byte-lane enables, bit i covers DAT_M[8i+7:8i]
//   DAT_M  write data from master
//   DAT_S  read data to master (registered, holds until the next read)
//   ACK    one-cycle completion strobe (registered)

module wb_line_mem #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned LATENCY    = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  CYC,
   input  logic                  STB,
   input  logic                  WE,
   input  logic [ADDR_WIDTH-1:0] ADR,
   input  logic [15:0]           SEL,
   input  logic [127:0]          DAT_M,
   output logic [127:0]          DAT_S,
   output logic                  ACK
);

   localparam int unsigned LINE_W = 128;
   localparam int unsigned BYTES  = 16;
   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   // LATENCY-1 plus up to 7 jitter cycles fits in 9 bits
   localparam int unsigned CNT_W  = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     lat_load_c;
   logic                 req_c;
   logic                 accept_c;
   logic                 enter_resp_c;

   logic [ADDR_WIDTH-1:0] adr_q;
   logic                  we_q;
   logic [BYTES-1:0]      sel_q;
   logic [LINE_W-1:0]     dat_q;

   logic [ADDR_WIDTH-1:0] eff_adr_c;
   logic                  eff_we_c;
   logic [BYTES-1:0]      eff_sel_c;
   logic [LINE_W-1:0]     eff_dat_c;

   logic [LINE_W-1:0]     mem [DEPTH];

   assign req_c = CYC & STB;

`ifdef WB_MEM_JITTER_EN
   logic [7:0] lfsr_q;
   logic       lfsr_fb_c;

   // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per accepted request
   assign lfsr_fb_c = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lfsr_q <= 8'hA5;
      end else if (accept_c) begin
         lfsr_q <= {lfsr_q[6:0], lfsr_fb_c};
      end
   end

   // Extra delay uses the LFSR value before this accept's shift
   assign lat_load_c = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_q[2:0]);
`else
   assign lat_load_c = CNT_W'(LATENCY - 1);
`endif

   // Next-state logic: accept in IDLE, count down in BUSY, single ACK cycle in RESP
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_c) begin
               accept_c = 1'b1;
               cnt_d    = lat_load_c;
               state_d  = (lat_load_c == CNT_W'(0)) ? RESP : BUSY;
            end
         end
         BUSY: begin
            if (!req_c) begin
               // master withdrew the request: abort without ACK or write
               state_d = IDLE;
               cnt_d   = CNT_W'(0);
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
               cnt_d   = CNT_W'(0);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = CNT_W'(0);
         end
      endcase
   end

   // RESP is always left after one cycle, so state_d == RESP means entry
   assign enter_resp_c = (state_d == RESP);

   // With a zero count the accept edge is also the RESP entry edge, so the
   // live bus inputs must be used instead of the not-yet-loaded latches
   assign eff_adr_c = accept_c ? ADR   : adr_q;
   assign eff_we_c  = accept_c ? WE    : we_q;
   assign eff_sel_c = accept_c ? SEL   : sel_q;
   assign eff_dat_c = accept_c ? DAT_M : dat_q;

   // State and counter registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= CNT_W'(0);
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture at accept; later input changes are ignored
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         adr_q <= ADDR_WIDTH'(0);
         we_q  <= 1'b0;
         sel_q <= BYTES'(0);
         dat_q <= LINE_W'(0);
      end else if (accept_c) begin
         adr_q <= ADR;
         we_q  <= WE;
         sel_q <= SEL;
         dat_q <= DAT_M;
      end
   end

   // Registered response: ACK pulse and read data loaded on RESP entry
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ACK   <= 1'b0;
         DAT_S <= LINE_W'(0);
      end else begin
         ACK <= enter_resp_c;
         if (enter_resp_c && !eff_we_c) begin
            DAT_S <= mem[eff_adr_c];
         end
      end
   end

   // Byte-masked line write committed on RESP entry; array has no reset
   always_ff @(posedge CLK) begin
      if (RST_N && enter_resp_c && eff_we_c) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (eff_sel_c[b]) begin
               mem[eff_adr_c][8*b +: 8] <= eff_dat_c[8*b +: 8];
            end
         end
      end
   end

endmodule
